// File: rtl/seqpu_bus_pkg.sv
// ============================================================================
// Module   : seqpu_bus_pkg
// Brief    : Shared constants and types for the seqpu bus target.
//            Holds the I/O page addresses, the UART state encoding and the
//            status register bit positions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seqpu_bus_pkg;

   // I/O page register addresses
   localparam logic [15:0] ADDR_UART  = 16'hFF00;
   localparam logic [15:0] ADDR_GPIO  = 16'hFF01;
   localparam logic [15:0] ADDR_TIMER = 16'hFF02;

   // UART transmitter states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Bit positions inside the UART status word
   localparam int BUSY_BIT = 0;
   localparam int OVR_BIT  = 1;

endpackage

`default_nettype wire

// File: rtl/seqpu_uart_tx.sv
// ============================================================================
// Module   : seqpu_uart_tx
// Brief    : 8N1 UART transmitter. A start pulse in IDLE latches a byte and
//            sends start bit, 8 data bits LSB first and a stop bit, each held
//            CLKS_PER_BIT clocks. busy is high for the whole frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seqpu_uart_tx
   import seqpu_bus_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] byte_in,
   output logic       tx,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   uart_state_t   state;
   uart_state_t   next_state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_done;

   assign bit_done = (cnt == '0);

   // State register; reset returns to IDLE at once, even mid-frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: advance on each bit-period boundary
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = START;
         START:   if (bit_done) next_state = DATA;
         DATA:    if (bit_done && (bit_idx == 3'd7)) next_state = STOP;
         STOP:    if (bit_done) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Bit-period down-counter, data bit index and byte latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'd0;
      end else if (state == IDLE) begin
         cnt     <= RELOAD;
         bit_idx <= 3'd0;
         if (start) begin
            shreg <= byte_in;
         end
      end else if (bit_done) begin
         cnt <= RELOAD;
         if (state == DATA) begin
            bit_idx <= bit_idx + 3'd1;
         end
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      tx   = 1'b1;
      busy = (state != IDLE);
      case (state)
         START:   tx = 1'b0;
         DATA:    tx = shreg[bit_idx];
         default: tx = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/seqpu_bus_target.sv
// ============================================================================
// Module   : seqpu_bus_target
// Brief    : Memory-side responder for the seqpu CPU bus. Word RAM plus an
//            I/O page with UART transmitter, GPIO register and a free-running
//            timer. Read data is registered (one cycle latency) and reads
//            always see the value from before any same-edge write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seqpu_bus_target
   import seqpu_bus_pkg::*;
#(
   parameter int          RAM_AW       = 12,
   parameter int          CLKS_PER_BIT = 16,
   parameter logic [15:0] GPIO_RESET   = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] address,
   input  logic [15:0] wdata,
   input  logic        wren_n,
   output logic [15:0] rdata,
   output logic        tx,
   output logic [15:0] gpio
);

   localparam int RAM_WORDS = 1 << RAM_AW;

   logic [15:0]       ram [RAM_WORDS];
   logic [RAM_AW-1:0] ram_idx;
   logic              in_ram;
   logic              is_uart;
   logic              is_gpio;
   logic              is_timer;
   logic              wr;
   logic              uart_busy;
   logic              uart_start;
   logic              uart_drop;
   logic              overrun;
   logic [15:0]       timer;
   logic [15:0]       status;
   logic [15:0]       rd_val;

   assign ram_idx  = address[RAM_AW-1:0];
   assign in_ram   = (address[15:RAM_AW] == '0);
   assign is_uart  = (address == ADDR_UART);
   assign is_gpio  = (address == ADDR_GPIO);
   assign is_timer = (address == ADDR_TIMER);
   assign wr       = ~wren_n;

   // A write while busy (including the edge busy clears) is dropped
   assign uart_start = wr & is_uart & ~uart_busy;
   assign uart_drop  = wr & is_uart & uart_busy;

   seqpu_uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk     (clk),
      .rst     (rst),
      .start   (uart_start),
      .byte_in (wdata[7:0]),
      .tx      (tx),
      .busy    (uart_busy)
   );

   // Read mux; every source is a register or RAM word, sampled into rdata
   always_comb begin
      status           = 16'h0000;
      status[BUSY_BIT] = uart_busy;
      status[OVR_BIT]  = overrun;
      rd_val           = 16'h0000;
      if (in_ram) begin
         rd_val = ram[ram_idx];
      end else if (is_uart) begin
         rd_val = status;
      end else if (is_gpio) begin
         rd_val = gpio;
      end else if (is_timer) begin
         rd_val = timer;
      end
   end

   // Registered read data: captures pre-write values, so reads are read-before-write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= 16'h0000;
      end else begin
         rdata <= rd_val;
      end
   end

   // RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (wr && in_ram) begin
         ram[ram_idx] <= wdata;
      end
   end

   // GPIO output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpio <= GPIO_RESET;
      end else if (wr && is_gpio) begin
         gpio <= wdata;
      end
   end

   // Free-running timer; a load counts as this edge's tick so counting resumes at wdata+1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer <= 16'h0000;
      end else if (wr && is_timer) begin
         timer <= wdata + 16'd1;
      end else begin
         timer <= timer + 16'd1;
      end
   end

   // Sticky overrun flag: set by a dropped write, cleared by a status read, set wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (uart_drop) begin
         overrun <= 1'b1;
      end else if (is_uart) begin
         overrun <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seqpu_bus_target.sv
// ============================================================================
// Module   : tb_seqpu_bus_target
// Brief    : Directed self-checking bench for seqpu_bus_target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seqpu_bus_target;

   localparam logic [15:0] GPIO_R = 16'hA5C3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] address = 16'h0000;
   logic [15:0] wdata = 16'h0000;
   logic        wren_n = 1'b1;
   logic [15:0] rdata;
   logic        tx;
   logic [15:0] gpio;

   int checks = 0;
   int errors = 0;

   seqpu_bus_target #(
      .RAM_AW       (12),
      .CLKS_PER_BIT (4),
      .GPIO_RESET   (GPIO_R)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .address (address),
      .wdata   (wdata),
      .wren_n  (wren_n),
      .rdata   (rdata),
      .tx      (tx),
      .gpio    (gpio)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      address = a;
      wdata   = d;
      wren_n  = 1'b0;
      cyc();
      wren_n  = 1'b1;
   endtask

   task automatic rd(input logic [15:0] a);
      address = a;
      wren_n  = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      checks++;
      if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want %h", rdata, 16'h0000); end
      checks++;
      if (gpio !== GPIO_R) begin errors++; $display("FAIL reset_gpio: got %h want %h", gpio, GPIO_R); end
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
      @(negedge clk);
      rst = 1'b0;
      rd(16'hFF02);
      checks++;
      if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_timer: got %h want %h", rdata, 16'h0000); end
   endtask

   task automatic test_ram();
      wr(16'h0000, 16'h1234);
      wr(16'h0123, 16'hBEEF);
      rd(16'h0123);
      checks++;
      if (rdata !== 16'hBEEF) begin errors++; $display("FAIL ram_read: got %h want %h", rdata, 16'hBEEF); end
      wr(16'h1000, 16'hDEAD);
      rd(16'h1000);
      checks++;
      if (rdata !== 16'h0000) begin errors++; $display("FAIL ram_outside: got %h want %h", rdata, 16'h0000); end
      rd(16'h0000);
      checks++;
      if (rdata !== 16'h1234) begin errors++; $display("FAIL ram_no_alias: got %h want %h", rdata, 16'h1234); end
      rd(16'h0FFF);
      wr(16'h0FFF, 16'h7E57);
      rd(16'h0FFF);
      checks++;
      if (rdata !== 16'h7E57) begin errors++; $display("FAIL ram_top_word: got %h want %h", rdata, 16'h7E57); end
   endtask

   task automatic test_read_before_write();
      wr(16'h0005, 16'h1111);
      wr(16'h0005, 16'h2222);
      checks++;
      if (rdata !== 16'h1111) begin errors++; $display("FAIL rbw_old: got %h want %h", rdata, 16'h1111); end
      rd(16'h0005);
      checks++;
      if (rdata !== 16'h2222) begin errors++; $display("FAIL rbw_new: got %h want %h", rdata, 16'h2222); end
   endtask

   task automatic test_gpio();
      wr(16'hFF01, 16'h5A5A);
      checks++;
      if (gpio !== 16'h5A5A) begin errors++; $display("FAIL gpio_out: got %h want %h", gpio, 16'h5A5A); end
      rd(16'hFF01);
      checks++;
      if (rdata !== 16'h5A5A) begin errors++; $display("FAIL gpio_read: got %h want %h", rdata, 16'h5A5A); end
      wr(16'hFF03, 16'hFFFF);
      rd(16'hFF03);
      checks++;
      if (rdata !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %h want %h", rdata, 16'h0000); end
   endtask

   task automatic test_timer();
      wr(16'hFF02, 16'hFFFE);
      rd(16'hFF02);
      checks++;
      if (rdata !== 16'hFFFF) begin errors++; $display("FAIL timer_load: got %h want %h", rdata, 16'hFFFF); end
      rd(16'hFF02);
      checks++;
      if (rdata !== 16'h0000) begin errors++; $display("FAIL timer_wrap: got %h want %h", rdata, 16'h0000); end
      rd(16'hFF02);
      checks++;
      if (rdata !== 16'h0001) begin errors++; $display("FAIL timer_count: got %h want %h", rdata, 16'h0001); end
   endtask

   task automatic test_uart();
      logic [9:0] frame;
      frame = 10'b1_1010_0101_0;
      wr(16'hFF00, 16'h00A5);
      for (int k = 0; k < 40; k++) begin
         checks++;
         if (tx !== frame[k/4]) begin
            errors++;
            $display("FAIL uart_tx cycle %0d: got %b want %b", k, tx, frame[k/4]);
         end
         if (k == 7) begin
            checks++;
            if (rdata !== 16'h0001) begin errors++; $display("FAIL uart_status_busy: got %h want %h", rdata, 16'h0001); end
         end
         if (k == 12) begin
            checks++;
            if (rdata !== 16'h0003) begin errors++; $display("FAIL uart_overrun_set: got %h want %h", rdata, 16'h0003); end
         end
         if (k == 13) begin
            checks++;
            if (rdata !== 16'h0001) begin errors++; $display("FAIL uart_overrun_clear: got %h want %h", rdata, 16'h0001); end
         end
         wren_n  = 1'b1;
         address = 16'h0000;
         if (k == 6 || k == 11 || k == 12) begin
            address = 16'hFF00;
         end
         if (k == 10) begin
            address = 16'hFF00;
            wdata   = 16'h00FF;
            wren_n  = 1'b0;
         end
         cyc();
      end
      wren_n = 1'b1;
      rd(16'hFF00);
      checks++;
      if (rdata !== 16'h0000) begin errors++; $display("FAIL uart_status_idle: got %h want %h", rdata, 16'h0000); end
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL uart_tx_idle: got %b want 1", tx); end
   endtask

   task automatic test_reset_midframe();
      wr(16'hFF00, 16'h005A);
      for (int k = 0; k < 12; k++) begin
         rd(16'hFF01);
      end
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL midframe_tx: got %b want 0", tx); end
      checks++;
      if (rdata !== 16'h5A5A) begin errors++; $display("FAIL midframe_rdata: got %h want %h", rdata, 16'h5A5A); end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
      checks++;
      if (rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata: got %h want %h", rdata, 16'h0000); end
      checks++;
      if (gpio !== GPIO_R) begin errors++; $display("FAIL rst_gpio: got %h want %h", gpio, GPIO_R); end
      @(negedge clk);
      rst = 1'b0;
      rd(16'hFF02);
      checks++;
      if (rdata !== 16'h0000) begin errors++; $display("FAIL rst_timer: got %h want %h", rdata, 16'h0000); end
      rd(16'hFF00);
      checks++;
      if (rdata !== 16'h0000) begin errors++; $display("FAIL rst_status: got %h want %h", rdata, 16'h0000); end
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx_after: got %b want 1", tx); end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_read_before_write();
      test_gpio();
      test_timer();
      test_uart();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
